spm_product_deser: RTL and testbench
====================================

// Module: spm_product_deser
// PURPOSE
// - Collects the serial product from the SPM carry-save chain: samples the last CSA stage's
//   registered sum bit (LSB first) for 2*WIDTH cycles and assembles the parallel product.
// - Sits directly downstream of the final genblk1[].csa.sum register.
// - Presents the product on a valid/ready port to the consumer. Sticky error on lost data.
// PARAMETERS
// - WIDTH  32  multiplicand/multiplier width; product is 2*WIDTH bits
// - CNT_W  $clog2(2*WIDTH)  bit-counter width (derived, do not override)
// PORTS
// - clk      in   1        single clock, all state on rising edge
// - rst      in   1        synchronous, active-low reset (rst==0 resets on next clk edge)
// - start    in   1        1-cycle pulse from SPM control, coincident with product bit 0 on sum_bit
// - sum_bit  in   1        serial product bit from last CSA stage sum, LSB first
// - p_valid  out  1        product holds an unconsumed result
// - p_ready  in   1        consumer accepts product when p_valid&&p_ready
// - product  out  2*WIDTH  assembled product, stable while p_valid
// - busy     out  1        capture in progress (state SHIFT)
// - overrun  out  1        sticky: start ignored or result dropped; cleared only by reset
// BEHAVIOUR
// - Reset (rst==0 at edge): state=IDLE, cnt=0, shreg=0, product=0, p_valid=0, busy=0, overrun=0.
//   Reset mid-capture discards the partial product; an already-held product is discarded too.
// - FSM states: IDLE, SHIFT.
// - IDLE: if start: shreg <= {sum_bit, shreg[2W-1:1]}, cnt <= 1, state -> SHIFT. Otherwise hold.
// - SHIFT: each cycle shreg <= {sum_bit, shreg[2W-1:1]}, cnt <= cnt+1.
//   When cnt==2W-1 (last bit sampled this cycle), the completion word is {sum_bit, shreg[2W-1:1]}.
//   State -> IDLE and cnt <= 0.
// - Completion, output slot free (p_valid==0, or p_valid&&p_ready in the same cycle):
//   product <= completion word, p_valid <= 1.
// - Completion, output slot full (p_valid&&!p_ready): the new word is dropped, product is held,
//   overrun <= 1.
// - start while in SHIFT (including the last-bit cycle): ignored, capture continues
//   unaffected, overrun <= 1.
// - Handshake: p_valid&&p_ready with no completion in that cycle -> p_valid <= 0, product
//   holds its last value. p_valid never drops without p_ready. product never changes while
//   p_valid&&!p_ready.
// - Latency: start in cycle 0 -> last bit sampled at end of cycle 2W-1 -> p_valid=1 from
//   cycle 2W.
// - Back-to-back: the next start may arrive in cycle 2W (state is IDLE again), so streams
//   may abut with zero gap.
// - busy = (state==SHIFT), registered.
// - sum_bit is ignored in IDLE without start.
// - No arithmetic on the bits: the product is the raw bit collection; sign handling stays
//   upstream.
// TESTING (WIDTH=4, product 8 bits)
// - Reset: hold rst=0 two cycles from random state -> p_valid=0, product=8'h00, busy=0,
//   overrun=0.
// - Single product: start + bits 1,0,1,0,0,1,0,1, p_ready=1 -> busy cycles 1-7,
//   p_valid=1 at cycle 8, product=8'hA5, p_valid=0 at cycle 9.
// - Backpressure: p_ready=0, capture 8'hA5 then 8'h3C -> product stays 8'hA5, overrun=1
//   at cycle 16. p_ready=1 -> p_valid falls.
// - Illegal start: start again at bit 3 of an 8'h5A stream -> overrun=1,
//   product=8'h5A at cycle 8.
// - Reset mid-capture: rst=0 at bit 4 -> busy=0, p_valid=0.
//   Next stream 8'hFF -> product=8'hFF, overrun=0.
// - Back-to-back: start at cycles 0 and 8 with 8'h01 then 8'h80, p_ready=1 ->
//   p_valid at 8 (8'h01) and 16 (8'h80), overrun=0.

Source files
------------

// File: rtl/spm_product_deser.sv
// spm_product_deser
// Deserialises the SPM product. The sum bit of the last CSA stage is sampled
// LSB first for 2*WIDTH cycles. The assembled word is offered on a valid/ready
// port. A sticky overrun flag records a start that was ignored or a result that
// was dropped.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; sum_bit is ignored
// SHIFT | capturing bits 1..2W-1; start is ignored and flagged as overrun
module spm_product_deser #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(2*WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sum_bit,
    output logic               p_valid,
    input  logic               p_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               overrun
);

    localparam int PW = 2*WIDTH;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PW-1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic [PW-1:0]    shreg, next_shreg;
    logic [PW-1:0]    next_product;
    logic             next_p_valid;
    logic             next_overrun;
    logic [PW-1:0]    shift_word;
    logic             complete;
    logic             slot_free;

    // The incoming bit enters at the top, so after 2W shifts bit 0 is at the LSB.
    assign shift_word = {sum_bit, shreg[PW-1:1]};

    // The output slot can take a new word when it is empty or is drained this cycle.
    assign slot_free = !p_valid || p_ready;

    // Next-state logic for the capture FSM, the output slot and the overrun flag.
    always_comb begin
        next_state   = state;
        next_cnt     = cnt;
        next_shreg   = shreg;
        next_product = product;
        next_p_valid = p_valid;
        next_overrun = overrun;
        complete     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    next_shreg = shift_word;
                    next_cnt   = CNT_W'(1);
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                next_shreg = shift_word;
                next_cnt   = cnt + CNT_W'(1);
                if (start) begin
                    next_overrun = 1'b1;
                end
                if (cnt == LAST_BIT) begin
                    complete   = 1'b1;
                    next_cnt   = '0;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase

        if (complete) begin
            if (slot_free) begin
                next_product = shift_word;
                next_p_valid = 1'b1;
            end else begin
                next_overrun = 1'b1;
            end
        end else if (p_valid && p_ready) begin
            next_p_valid = 1'b0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            product <= '0;
            p_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= next_cnt;
            shreg   <= next_shreg;
            product <= next_product;
            p_valid <= next_p_valid;
            overrun <= next_overrun;
        end
    end

    // The FSM state is itself a register, so busy comes straight from a flop.
    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_spm_product_deser.sv
// tb_spm_product_deser
// Directed and random stimulus for spm_product_deser with WIDTH=4. A
// transaction-level model collects the sampled bits into a word and tracks the
// single-entry output slot.
module tb_spm_product_deser;

    logic       clk;
    logic       rst;
    logic       start;
    logic       sum_bit;
    logic       p_valid;
    logic       p_ready;
    logic [7:0] product;
    logic       busy;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit         m_known = 0;
    bit         m_cap   = 0;
    int         m_n     = 0;
    logic [7:0] m_word  = '0;
    bit         m_valid = 0;
    logic [7:0] m_prod  = '0;
    bit         m_ovr   = 0;

    spm_product_deser #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sum_bit (sum_bit),
        .p_valid (p_valid),
        .p_ready (p_ready),
        .product (product),
        .busy    (busy),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of the model, using the inputs that were present at the edge.
    task automatic model_update();
        bit done;
        done = 0;
        if (!rst) begin
            m_known = 1;
            m_cap   = 0;
            m_n     = 0;
            m_word  = '0;
            m_valid = 0;
            m_prod  = '0;
            m_ovr   = 0;
        end else begin
            if (!m_cap) begin
                if (start) begin
                    m_cap  = 1;
                    m_word = 8'(sum_bit);
                    m_n    = 1;
                end
            end else begin
                if (start) m_ovr = 1;
                m_word = m_word + (8'(sum_bit) << m_n);
                m_n++;
                if (m_n == 8) begin
                    done  = 1;
                    m_cap = 0;
                end
            end
            if (done) begin
                if (!m_valid || p_ready) begin
                    m_prod  = m_word;
                    m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_valid && p_ready) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        if (m_known) begin
            chk("p_valid", 8'(p_valid), 8'(m_valid));
            chk("product", product, m_prod);
            chk("busy", 8'(busy), 8'(m_cap));
            chk("overrun", 8'(overrun), 8'(m_ovr));
        end
    endtask

    // Sends one 8-bit stream LSB first; a second start is raised at bit bad_at.
    task automatic send(input logic [7:0] w, input int bad_at);
        for (int i = 0; i < 8; i++) begin
            start   = (i == 0) || (i == bad_at);
            sum_bit = w[i];
            step();
        end
        start   = 1'b0;
        sum_bit = 1'(($urandom >> 3) & 1);
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        sum_bit = 1'b0;
        p_ready = 1'b0;
        step();
        rst = 1'b1;

        // random state before the reset test
        for (int i = 0; i < 24; i++) begin
            start   = ($urandom_range(0, 3) == 0);
            sum_bit = 1'($urandom & 1);
            p_ready = 1'($urandom & 1);
            step();
        end
        start = 1'b0;
        rst   = 1'b0;
        step();
        step();
        chk("rst_p_valid", 8'(p_valid), 8'h00);
        chk("rst_product", product, 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_overrun", 8'(overrun), 8'h00);
        rst = 1'b1;

        // single product
        p_ready = 1'b1;
        send(8'hA5, -1);
        chk("single_valid", 8'(p_valid), 8'h01);
        chk("single_product", product, 8'hA5);
        step();
        chk("single_drain", 8'(p_valid), 8'h00);

        // backpressure
        p_ready = 1'b0;
        send(8'hA5, -1);
        send(8'h3C, -1);
        chk("bp_product", product, 8'hA5);
        chk("bp_overrun", 8'(overrun), 8'h01);
        chk("bp_valid", 8'(p_valid), 8'h01);
        p_ready = 1'b1;
        step();
        chk("bp_drain", 8'(p_valid), 8'h00);

        // illegal start
        rst = 1'b0;
        step();
        rst = 1'b1;
        send(8'h5A, 3);
        chk("ill_overrun", 8'(overrun), 8'h01);
        chk("ill_product", product, 8'h5A);
        chk("ill_valid", 8'(p_valid), 8'h01);

        // reset mid-capture, with a held product present
        p_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start   = (i == 0);
            sum_bit = 1'($urandom & 1);
            step();
        end
        start = 1'b0;
        rst   = 1'b0;
        step();
        chk("midrst_busy", 8'(busy), 8'h00);
        chk("midrst_valid", 8'(p_valid), 8'h00);
        rst     = 1'b1;
        p_ready = 1'b1;
        send(8'hFF, -1);
        chk("midrst_product", product, 8'hFF);
        chk("midrst_overrun", 8'(overrun), 8'h00);

        // back-to-back streams
        send(8'h01, -1);
        chk("b2b_valid0", 8'(p_valid), 8'h01);
        chk("b2b_product0", product, 8'h01);
        send(8'h80, -1);
        chk("b2b_valid1", 8'(p_valid), 8'h01);
        chk("b2b_product1", product, 8'h80);
        chk("b2b_overrun", 8'(overrun), 8'h00);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 99) != 0);
            start   = ($urandom_range(0, 5) == 0);
            sum_bit = 1'($urandom & 1);
            p_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
